// File: rtl/led_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
// Optional leading-zero blanking is controlled by LED_SCAN_LEADING_ZERO_BLANK_EN.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // True when digit idx sits above the most significant nonzero nibble.
  // Digit 0 is never treated as a leading zero.
  function automatic logic leading_zero(input logic [1:0] idx, input logic [15:0] v);
    logic [15:0] upper;
    upper = v >> {idx, 2'b00};
    return (idx != 2'd0) && (upper == 16'h0000);
  endfunction

  function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/led_scan_controller_decoder.sv
// LEDdecoder: hex nibble to active-low 7-segment pattern, bit 6 = segment a,
// bit 0 = segment g.
module LEDdecoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/led_scan_controller.sv
// Time-multiplexed 4-digit common-anode display driver with per-digit dead-time.
// Define LED_SCAN_LEADING_ZERO_BLANK_EN to blank digits above the top nonzero nibble.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  LED,
  output logic        frame_done
);

  localparam int CNT_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      value_q;
  logic [3:0]       nibble_q, nibble_d;
  logic [3:0]       an_q;
  logic [6:0]       led_q;
  logic             frame_done_q;

  logic       show_done;
  logic       gap_done;
  logic       show_entry;
  logic [1:0] entry_idx;
  logic       blank_d;
  logic       lit_d;
  logic [6:0] seg_w;

  always_comb begin
    show_done  = (state_q == SHOW) && (cnt_q == SHOW_LAST);
    gap_done   = HAS_GAP && (state_q == GAP) && (cnt_q == GAP_LAST);
    entry_idx  = (state_q == IDLE) ? 2'd0 : idx_q + 2'd1;
    show_entry = enable && ((state_q == IDLE) || gap_done || (show_done && !HAS_GAP));

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else if (show_entry) begin
      state_d = SHOW;
      idx_d   = entry_idx;
      cnt_d   = '0;
    end else if (show_done) begin
      state_d = GAP;
      cnt_d   = '0;
    end

    // Nibble is frozen at SHOW entry, so a load mid-digit waits for the next digit.
    nibble_d = show_entry ? value_q[{entry_idx, 2'b00} +: 4] : nibble_q;
  end

`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
  logic blank_q;

  assign blank_d = show_entry ? leading_zero(entry_idx, value_q) : blank_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  assign blank_d = 1'b0;
`endif

  assign lit_d = (state_d == SHOW) && digit_en[idx_d] && !blank_d;

  // Decoder is fed the next-cycle nibble so segments and anode move on the same edge.
  LEDdecoder u_decoder (
    .nibble_i (nibble_d),
    .seg_o    (seg_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      value_q      <= 16'h0000;
      nibble_q     <= 4'h0;
      an_q         <= AN_OFF;
      led_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      nibble_q <= nibble_d;
      if (load) begin
        value_q <= value;
      end
      an_q         <= lit_d ? an_onehot_low(idx_d) : AN_OFF;
      led_q        <= lit_d ? seg_w : SEG_BLANK;
      frame_done_q <= enable && show_done && (idx_q == LAST_DIGIT);
    end
  end

  assign an         = an_q;
  assign LED        = led_q;
  assign frame_done = frame_done_q;

endmodule
